// File: rtl/dec_lut_encoder9bits_clk.sv
// Purpose : triangular-number encoder, W = N*(N+1)/2 built one addend per clock.
// Latency : w_valid/done rise exactly N+1 clock edges after the accept edge.
// Backpr. : in_ready low while accumulating; requests seen while busy are dropped.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   in_valid in   request strobe, N_in is valid
//   in_ready out  encoder idle and able to accept a request
//   N_in     in   index to encode (N_BITS wide)
//   busy     out  accumulation in progress (always the inverse of in_ready)
//   W        out  encoded value, held until the next completion (W_BITS wide)
//   w_valid  out  W belongs to the most recently accepted N (level)
//   done     out  one-cycle pulse on the edge W is updated
module dec_lut_encoder9bits_clk #(
    parameter int N_BITS = 9,
    parameter int W_BITS = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N_in,
    output logic              busy,
    output logic [W_BITS-1:0] W,
    output logic              w_valid,
    output logic              done
);

    // The largest result (2^N_BITS-1)*2^N_BITS/2 needs 2*N_BITS-1 bits.
    generate
        if (W_BITS < 2 * N_BITS - 1) begin : g_w_bits_too_small
            $error("dec_lut_encoder9bits_clk: W_BITS must be >= 2*N_BITS-1");
        end
    endgenerate

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACC  = 1'b1;

    logic              state_q, state_d;
    logic [N_BITS-1:0] n_q, n_d;
    logic [N_BITS-1:0] k_q, k_d;
    logic [W_BITS-1:0] acc_q, acc_d;
    logic [W_BITS-1:0] w_q, w_d;
    logic              w_valid_q, w_valid_d;
    logic              done_q, done_d;

    // Next addend (k+1), zero-extended so the running sum is carried at full width.
    // k never exceeds n, so k+1 cannot wrap within N_BITS.
    logic [W_BITS-1:0] addend;
    assign addend = W_BITS'(k_q) + W_BITS'(1);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        acc_d     = acc_q;
        w_d       = w_q;
        w_valid_d = w_valid_q;
        done_d    = 1'b0;       // done is a single-cycle pulse

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    n_d       = N_in;
                    k_d       = '0;
                    acc_d     = '0;
                    // Old W stays visible but is no longer tied to the new request.
                    w_valid_d = 1'b0;
                    state_d   = ST_ACC;
                end
            end
            ST_ACC: begin
                if (k_q == n_q) begin
                    // acc already holds 1+2+...+n; N=0 lands here on the first ACC cycle.
                    w_d       = acc_q;
                    w_valid_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    acc_d = acc_q + addend;
                    k_d   = k_q + N_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            w_q       <= '0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            done_q    <= done_d;
        end
    end

    // Handshake is decoded straight from the state register so an async reset
    // raises in_ready in the same cycle it is asserted.
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_ACC);
    assign W        = w_q;
    assign w_valid  = w_valid_q;
    assign done     = done_q;

endmodule
